tcp_msg_ptr_poller_engine: RTL and testbench

//  Services one flow per poll: pops a flow ID, fetches its pending message request and its base/end ring indices, then decides whether the request is satisfiable.
//  If it is, the block sends a notification. If not, the flow is requeued. If it can never be satisfied, the request is dropped as an error.

---
 rtl/tcp_msg_ptr_poller_engine.sv | 184 ++++++++++++++++++
 tb/tb_tcp_msg_ptr_poller_engine.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_msg_ptr_poller_engine.sv
// Flow poller: pops a flow, fetches its message request and ring indices, then
// notifies the app, requeues the flow, or drops an unsatisfiable request.
module tcp_msg_ptr_poller_engine #(
  parameter int FLOWID_W        = 8,
  parameter int BUF_W           = 12,
  parameter int LEN_W           = 16,
  parameter int CHK_SPACE_EMPTY = 0,
  parameter int CNT_W           = 32,
  localparam int IDX_W          = BUF_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flowq_poller_val,
  input  logic [FLOWID_W-1:0] flowq_poller_flowid,
  output logic                poller_flowq_rdy,
  output logic                poller_flowq_wr_val,
  output logic [FLOWID_W-1:0] poller_flowq_wr_flowid,
  input  logic                flowq_poller_wr_rdy,
  output logic                poller_msgreq_rd_req_val,
  output logic [FLOWID_W-1:0] poller_msgreq_rd_req_flowid,
  input  logic                msgreq_poller_rd_req_rdy,
  input  logic                msgreq_poller_rd_resp_val,
  input  logic [LEN_W-1:0]    msgreq_poller_rd_resp_len,
  output logic                poller_msgreq_rd_resp_rdy,
  output logic                poller_idx_rd_req_val,
  output logic [FLOWID_W-1:0] poller_idx_rd_req_flowid,
  input  logic                idx_poller_rd_req_rdy,
  input  logic                idx_poller_rd_resp_val,
  input  logic [IDX_W-1:0]    idx_poller_rd_resp_base,
  input  logic [IDX_W-1:0]    idx_poller_rd_resp_end,
  output logic                poller_idx_rd_resp_rdy,
  output logic                poller_notif_val,
  output logic [FLOWID_W-1:0] poller_notif_flowid,
  output logic [IDX_W-1:0]    poller_notif_ptr,
  output logic [LEN_W-1:0]    poller_notif_len,
  input  logic                notif_poller_rdy,
  output logic                poller_bitvec_clr_val,
  output logic [FLOWID_W-1:0] poller_bitvec_clr_flowid,
  output logic                poller_err_val,
  output logic [CNT_W-1:0]    poller_notif_cnt,
  output logic [CNT_W-1:0]    poller_requeue_cnt
);

  localparam int CMP_W = (LEN_W > IDX_W) ? LEN_W : IDX_W;
  localparam logic [IDX_W-1:0] RING_IDX   = IDX_W'(1) << BUF_W;
  localparam logic [CMP_W-1:0] RING_BYTES = CMP_W'(RING_IDX);

  typedef enum logic [2:0] {
    S_READY, S_ISSUE, S_RESP, S_CALC, S_NOTIF, S_REQUEUE, S_ERR
  } state_t;

  state_t              state;
  logic [FLOWID_W-1:0] flowid_q;
  logic [LEN_W-1:0]    len_q;
  logic [IDX_W-1:0]    base_q;
  logic [IDX_W-1:0]    end_q;

  logic [IDX_W-1:0]    occ_raw;
  logic [IDX_W-1:0]    occ;
  logic [IDX_W-1:0]    avail;
  logic                len_too_big;
  logic                len_fits;

  // The latched flow ID is the payload of every flow-addressed output; it only
  // changes on a pop, after the trailing clear pulse has already gone out.
  assign poller_msgreq_rd_req_flowid = flowid_q;
  assign poller_idx_rd_req_flowid    = flowid_q;
  assign poller_flowq_wr_flowid      = flowid_q;
  assign poller_notif_flowid         = flowid_q;
  assign poller_bitvec_clr_flowid    = flowid_q;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    occ_raw     = end_q - base_q;
    occ         = (occ_raw > RING_IDX) ? RING_IDX : occ_raw;
    avail       = (CHK_SPACE_EMPTY != 0) ? (RING_IDX - occ) : occ;
    len_too_big = CMP_W'(len_q) > RING_BYTES;
    len_fits    = CMP_W'(len_q) <= CMP_W'(avail);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= S_READY;
      flowid_q                  <= '0;
      len_q                     <= '0;
      base_q                    <= '0;
      end_q                     <= '0;
      poller_flowq_rdy          <= 1'b0;
      poller_flowq_wr_val       <= 1'b0;
      poller_msgreq_rd_req_val  <= 1'b0;
      poller_msgreq_rd_resp_rdy <= 1'b0;
      poller_idx_rd_req_val     <= 1'b0;
      poller_idx_rd_resp_rdy    <= 1'b0;
      poller_notif_val          <= 1'b0;
      poller_notif_ptr          <= '0;
      poller_notif_len          <= '0;
      poller_bitvec_clr_val     <= 1'b0;
      poller_err_val            <= 1'b0;
      poller_notif_cnt          <= '0;
      poller_requeue_cnt        <= '0;
    end else begin
      poller_bitvec_clr_val <= 1'b0;
      poller_err_val        <= 1'b0;
      case (state)
        S_READY: begin
          if (poller_flowq_rdy && flowq_poller_val) begin
            flowid_q                 <= flowq_poller_flowid;
            poller_flowq_rdy         <= 1'b0;
            poller_msgreq_rd_req_val <= 1'b1;
            poller_idx_rd_req_val    <= 1'b1;
            state                    <= S_ISSUE;
          end else begin
            poller_flowq_rdy <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (msgreq_poller_rd_req_rdy) poller_msgreq_rd_req_val <= 1'b0;
          if (idx_poller_rd_req_rdy)    poller_idx_rd_req_val    <= 1'b0;
          if ((!poller_msgreq_rd_req_val || msgreq_poller_rd_req_rdy) &&
              (!poller_idx_rd_req_val    || idx_poller_rd_req_rdy)) begin
            poller_msgreq_rd_resp_rdy <= 1'b1;
            poller_idx_rd_resp_rdy    <= 1'b1;
            state                     <= S_RESP;
          end
        end
        S_RESP: begin
          if (poller_msgreq_rd_resp_rdy && msgreq_poller_rd_resp_val) begin
            len_q                     <= msgreq_poller_rd_resp_len;
            poller_msgreq_rd_resp_rdy <= 1'b0;
          end
          if (poller_idx_rd_resp_rdy && idx_poller_rd_resp_val) begin
            base_q                 <= idx_poller_rd_resp_base;
            end_q                  <= idx_poller_rd_resp_end;
            poller_idx_rd_resp_rdy <= 1'b0;
          end
          if ((!poller_msgreq_rd_resp_rdy || msgreq_poller_rd_resp_val) &&
              (!poller_idx_rd_resp_rdy    || idx_poller_rd_resp_val)) begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (len_too_big) begin
            poller_err_val        <= 1'b1;
            poller_bitvec_clr_val <= 1'b1;
            state                 <= S_ERR;
          end else if (len_fits) begin
            poller_notif_val <= 1'b1;
            poller_notif_ptr <= (CHK_SPACE_EMPTY != 0) ? end_q : base_q;
            poller_notif_len <= len_q;
            state            <= S_NOTIF;
          end else begin
            poller_flowq_wr_val <= 1'b1;
            state               <= S_REQUEUE;
          end
        end
        S_NOTIF: begin
          if (poller_notif_val && notif_poller_rdy) begin
            poller_notif_val      <= 1'b0;
            poller_bitvec_clr_val <= 1'b1;
            if (poller_notif_cnt != '1) poller_notif_cnt <= poller_notif_cnt + CNT_W'(1);
            poller_flowq_rdy      <= 1'b1;
            state                 <= S_READY;
          end
        end
        S_REQUEUE: begin
          // The active bit stays set: the flow is still pending in the poll queue.
          if (poller_flowq_wr_val && flowq_poller_wr_rdy) begin
            poller_flowq_wr_val <= 1'b0;
            if (poller_requeue_cnt != '1) poller_requeue_cnt <= poller_requeue_cnt + CNT_W'(1);
            poller_flowq_rdy    <= 1'b1;
            state               <= S_READY;
          end
        end
        S_ERR: begin
          poller_flowq_rdy <= 1'b1;
          state            <= S_READY;
        end
        default: state <= S_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_msg_ptr_poller_engine.sv
// Bench for tcp_msg_ptr_poller_engine: instance 0 runs RX mode, instance 1 TX mode,
// with expected outcomes queued per flow and compared when the DUT resolves it.
module tb_tcp_msg_ptr_poller_engine;
  localparam int FW = 8;
  localparam int BW = 12;
  localparam int LW = 16;
  localparam int IW = BW + 1;
  localparam int CW = 32;

  typedef enum logic [1:0] {K_NOTIF, K_REQUEUE, K_ERR} kind_t;
  typedef struct packed {
    kind_t          kind;
    logic [FW-1:0]  flowid;
    logic [IW-1:0]  ptr;
    logic [LW-1:0]  len;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst          [2];
  logic          fq_val       [2];
  logic [FW-1:0] fq_fid       [2];
  logic          fq_rdy       [2];
  logic          wr_val       [2];
  logic [FW-1:0] wr_fid       [2];
  logic          wr_rdy       [2];
  logic          mq_req_val   [2];
  logic [FW-1:0] mq_req_fid   [2];
  logic          mq_req_rdy   [2];
  logic          mq_resp_val  [2];
  logic [LW-1:0] mq_resp_len  [2];
  logic          mq_resp_rdy  [2];
  logic          ix_req_val   [2];
  logic [FW-1:0] ix_req_fid   [2];
  logic          ix_req_rdy   [2];
  logic          ix_resp_val  [2];
  logic [IW-1:0] ix_resp_base [2];
  logic [IW-1:0] ix_resp_end  [2];
  logic          ix_resp_rdy  [2];
  logic          nt_val       [2];
  logic [FW-1:0] nt_fid       [2];
  logic [IW-1:0] nt_ptr       [2];
  logic [LW-1:0] nt_len       [2];
  logic          nt_rdy       [2];
  logic          clr_val      [2];
  logic [FW-1:0] clr_fid      [2];
  logic          err_val      [2];
  logic [CW-1:0] nt_cnt       [2];
  logic [CW-1:0] rq_cnt       [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tcp_msg_ptr_poller_engine #(
      .FLOWID_W(FW), .BUF_W(BW), .LEN_W(LW), .CHK_SPACE_EMPTY(g), .CNT_W(CW)
    ) dut (
      .clk                         (clk),
      .rst                         (rst[g]),
      .flowq_poller_val            (fq_val[g]),
      .flowq_poller_flowid         (fq_fid[g]),
      .poller_flowq_rdy            (fq_rdy[g]),
      .poller_flowq_wr_val         (wr_val[g]),
      .poller_flowq_wr_flowid      (wr_fid[g]),
      .flowq_poller_wr_rdy         (wr_rdy[g]),
      .poller_msgreq_rd_req_val    (mq_req_val[g]),
      .poller_msgreq_rd_req_flowid (mq_req_fid[g]),
      .msgreq_poller_rd_req_rdy    (mq_req_rdy[g]),
      .msgreq_poller_rd_resp_val   (mq_resp_val[g]),
      .msgreq_poller_rd_resp_len   (mq_resp_len[g]),
      .poller_msgreq_rd_resp_rdy   (mq_resp_rdy[g]),
      .poller_idx_rd_req_val       (ix_req_val[g]),
      .poller_idx_rd_req_flowid    (ix_req_fid[g]),
      .idx_poller_rd_req_rdy       (ix_req_rdy[g]),
      .idx_poller_rd_resp_val      (ix_resp_val[g]),
      .idx_poller_rd_resp_base     (ix_resp_base[g]),
      .idx_poller_rd_resp_end      (ix_resp_end[g]),
      .poller_idx_rd_resp_rdy      (ix_resp_rdy[g]),
      .poller_notif_val            (nt_val[g]),
      .poller_notif_flowid         (nt_fid[g]),
      .poller_notif_ptr            (nt_ptr[g]),
      .poller_notif_len            (nt_len[g]),
      .notif_poller_rdy            (nt_rdy[g]),
      .poller_bitvec_clr_val       (clr_val[g]),
      .poller_bitvec_clr_flowid    (clr_fid[g]),
      .poller_err_val              (err_val[g]),
      .poller_notif_cnt            (nt_cnt[g]),
      .poller_requeue_cnt          (rq_cnt[g])
    );
  end

  int compared   = 0;
  int mismatched = 0;
  exp_t exp_q[$];
  logic [CW-1:0] exp_ncnt [2];
  logic [CW-1:0] exp_rcnt [2];

  task automatic idle(input int s);
    fq_val[s] = 1'b0; fq_fid[s] = '0; wr_rdy[s] = 1'b0;
    mq_req_rdy[s] = 1'b0; mq_resp_val[s] = 1'b0; mq_resp_len[s] = '0;
    ix_req_rdy[s] = 1'b0; ix_resp_val[s] = 1'b0; ix_resp_base[s] = '0; ix_resp_end[s] = '0;
    nt_rdy[s] = 1'b0;
  endtask

  // One flow end to end. Delays: idx req rdy held low for idx_dly cycles, msgreq
  // resp offered resp_gap cycles after the idx resp, notif rdy low notif_dly cycles.
  task automatic do_flow(input int s, input logic [FW-1:0] fid, input logic [IW-1:0] base,
                         input logic [IW-1:0] endi, input logic [LW-1:0] len,
                         input kind_t ek, input logic [IW-1:0] eptr, input int idx_dly,
                         input int resp_gap, input int notif_dly, input bit rst_in_notif,
                         output int out_cyc);
    exp_t e, got;
    kind_t k_obs;
    logic [FW-1:0] fid_obs;
    bit popped, outcome, m_resp_done, i_resp_done;
    int m_req_n, i_req_n, i_resp_cyc, notif_seen, clr_n, err_n, notif_n, wr_n, post;
    e.kind = ek; e.flowid = fid; e.ptr = eptr; e.len = len;
    exp_q.push_back(e);
    if (!rst_in_notif && ek == K_NOTIF) exp_ncnt[s]++;
    if (ek == K_REQUEUE) exp_rcnt[s]++;
    out_cyc = -1;

    fq_val[s] = 1'b1; fq_fid[s] = fid; popped = 0;
    for (int i = 0; i < 50 && !popped; i++) begin
      if (fq_rdy[s]) popped = 1;
      @(negedge clk);
    end
    fq_val[s] = 1'b0; fq_fid[s] = '0;
    if (!popped) begin
      compared++; mismatched++;
      $display("FAIL pop_timeout flow %0h: poll queue never popped", fid);
      void'(exp_q.pop_front());
      return;
    end

    m_req_n = 0; i_req_n = 0; m_resp_done = 0; i_resp_done = 0; i_resp_cyc = -1;
    notif_seen = -1; clr_n = 0; err_n = 0; notif_n = 0; wr_n = 0; post = 0; outcome = 0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      mq_req_rdy[s]   = 1'b1;
      ix_req_rdy[s]   = (cyc > idx_dly);
      ix_resp_val[s]  = (i_req_n > 0) && !i_resp_done;
      ix_resp_base[s] = base; ix_resp_end[s] = endi;
      mq_resp_val[s]  = (m_req_n > 0) && !m_resp_done &&
                        (resp_gap == 0 || (i_resp_cyc > 0 && cyc >= i_resp_cyc + resp_gap));
      mq_resp_len[s]  = len;
      if (nt_val[s] && notif_seen < 0) notif_seen = cyc;
      nt_rdy[s] = (notif_seen > 0) && (cyc >= notif_seen + notif_dly) && !rst_in_notif;
      wr_rdy[s] = 1'b1;

      if (mq_req_val[s]) begin
        compared++;
        if (mq_req_fid[s] !== fid) begin mismatched++; $display("FAIL msgreq_req_flowid got %0h want %0h", mq_req_fid[s], fid); end
        if (mq_req_rdy[s]) m_req_n++;
      end
      if (ix_req_val[s]) begin
        compared++;
        if (ix_req_fid[s] !== fid) begin mismatched++; $display("FAIL idx_req_flowid got %0h want %0h", ix_req_fid[s], fid); end
        if (ix_req_rdy[s]) i_req_n++;
      end
      if (ix_resp_val[s] && ix_resp_rdy[s]) begin i_resp_done = 1; i_resp_cyc = cyc; end
      if (mq_resp_val[s] && mq_resp_rdy[s]) m_resp_done = 1;
      if (clr_val[s]) begin
        clr_n++; compared++;
        if (clr_fid[s] !== fid) begin mismatched++; $display("FAIL clr_flowid got %0h want %0h", clr_fid[s], fid); end
      end
      if (err_val[s]) err_n++;
      if (nt_val[s]) begin
        compared++;
        if ({nt_fid[s], nt_ptr[s], nt_len[s]} !== {fid, eptr, len}) begin
          mismatched++;
          $display("FAIL notif_payload got fid=%0h ptr=%0h len=%0h want fid=%0h ptr=%0h len=%0h",
                   nt_fid[s], nt_ptr[s], nt_len[s], fid, eptr, len);
        end
        if (nt_rdy[s]) notif_n++;
      end
      if (wr_val[s]) begin
        compared++;
        if (wr_fid[s] !== fid) begin mismatched++; $display("FAIL requeue_flowid got %0h want %0h", wr_fid[s], fid); end
        if (wr_rdy[s]) wr_n++;
      end

      if (rst_in_notif && nt_val[s]) begin
        rst[s] = 1'b1;
        @(negedge clk);
        compared++;
        if ({fq_rdy[s], wr_val[s], mq_req_val[s], mq_resp_rdy[s], ix_req_val[s], ix_resp_rdy[s],
             nt_val[s], clr_val[s], err_val[s]} !== 9'b0 || nt_cnt[s] !== '0 || rq_cnt[s] !== '0) begin
          mismatched++;
          $display("FAIL reset_mid_notif outputs not cleared: notif_val=%0b notif_cnt=%0d requeue_cnt=%0d",
                   nt_val[s], nt_cnt[s], rq_cnt[s]);
        end
        rst[s] = 1'b0;
        idle(s);
        void'(exp_q.pop_front());
        exp_ncnt[s] = '0; exp_rcnt[s] = '0;
        return;
      end

      if (!outcome && ((nt_val[s] && nt_rdy[s]) || (wr_val[s] && wr_rdy[s]) || err_val[s])) begin
        outcome = 1; out_cyc = cyc;
        k_obs   = err_val[s] ? K_ERR : (nt_val[s] ? K_NOTIF : K_REQUEUE);
        fid_obs = err_val[s] ? clr_fid[s] : (nt_val[s] ? nt_fid[s] : wr_fid[s]);
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++; $display("FAIL scoreboard_empty: unexpected outcome %0d", k_obs);
        end else begin
          got = exp_q.pop_front();
          if (k_obs !== got.kind || fid_obs !== got.flowid) begin
            mismatched++;
            $display("FAIL outcome got kind=%0d fid=%0h want kind=%0d fid=%0h", k_obs, fid_obs, got.kind, got.flowid);
          end
        end
      end
      if (outcome) post++;
      if (post >= 3) break;
      @(negedge clk);
    end
    idle(s);

    compared++;
    if (!outcome) begin
      mismatched++; $display("FAIL outcome_timeout flow %0h: no notif/requeue/err", fid);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    compared++;
    if (m_req_n != 1 || i_req_n != 1) begin
      mismatched++; $display("FAIL req_count got msgreq=%0d idx=%0d want 1/1", m_req_n, i_req_n);
    end
    compared++;
    if (clr_n != ((ek == K_REQUEUE) ? 0 : 1) || err_n != ((ek == K_ERR) ? 1 : 0) ||
        notif_n != ((ek == K_NOTIF) ? 1 : 0) || wr_n != ((ek == K_REQUEUE) ? 1 : 0)) begin
      mismatched++;
      $display("FAIL event_counts got clr=%0d err=%0d notif=%0d requeue=%0d for kind %0d",
               clr_n, err_n, notif_n, wr_n, ek);
    end
    compared++;
    if (nt_cnt[s] !== exp_ncnt[s] || rq_cnt[s] !== exp_rcnt[s]) begin
      mismatched++;
      $display("FAIL counters got notif=%0d requeue=%0d want notif=%0d requeue=%0d",
               nt_cnt[s], rq_cnt[s], exp_ncnt[s], exp_rcnt[s]);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; idle(s); exp_ncnt[s] = '0; exp_rcnt[s] = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      compared++;
      if ({fq_rdy[s], wr_val[s], mq_req_val[s], mq_resp_rdy[s], ix_req_val[s], ix_resp_rdy[s],
           nt_val[s], clr_val[s], err_val[s]} !== 9'b0 || nt_cnt[s] !== '0 || rq_cnt[s] !== '0 ||
          nt_ptr[s] !== '0 || nt_len[s] !== '0) begin
        mismatched++; $display("FAIL reset_state inst %0d: outputs not zero", s);
      end
      rst[s] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_rx_basic();
    int c;
    do_flow(0, 8'h11, 13'h0010, 13'h0050, 16'h0040, K_NOTIF, 13'h0010, 0, 0, 0, 0, c);
    compared++;
    if (c != 4) begin mismatched++; $display("FAIL min_latency got cycle %0d want 4", c); end
  endtask

  task automatic test_rx_wrap();
    int c;
    do_flow(0, 8'h22, 13'h1FF0, 13'h0010, 16'h0020, K_NOTIF,   13'h1FF0, 0, 0, 0, 0, c);
    do_flow(0, 8'h23, 13'h1FF0, 13'h0010, 16'h0021, K_REQUEUE, 13'h0000, 0, 0, 0, 0, c);
  endtask

  task automatic test_tx();
    int c;
    do_flow(1, 8'h31, 13'h0000, 13'h1000, 16'h0001, K_REQUEUE, 13'h0000, 0, 0, 0, 0, c);
    do_flow(1, 8'h32, 13'h0000, 13'h0FFF, 16'h0001, K_NOTIF,   13'h0FFF, 0, 0, 0, 0, c);
    do_flow(1, 8'h33, 13'h0800, 13'h0800, 16'h1000, K_NOTIF,   13'h0800, 0, 0, 0, 0, c);
    do_flow(1, 8'h34, 13'h0800, 13'h0801, 16'h1000, K_REQUEUE, 13'h0000, 0, 0, 0, 0, c);
  endtask

  task automatic test_err_and_zero();
    int c;
    do_flow(0, 8'h41, 13'h0010, 13'h0050, 16'h1001, K_ERR,   13'h0000, 0, 0, 0, 0, c);
    do_flow(1, 8'h42, 13'h0000, 13'h0000, 16'h1001, K_ERR,   13'h0000, 0, 0, 0, 0, c);
    do_flow(0, 8'h43, 13'h0030, 13'h0030, 16'h0000, K_NOTIF, 13'h0030, 0, 0, 0, 0, c);
    do_flow(0, 8'h44, 13'h0000, 13'h1000, 16'h1000, K_NOTIF, 13'h0000, 0, 0, 0, 0, c);
    do_flow(0, 8'h45, 13'h1F00, 13'h0F00, 16'hFFFF, K_ERR,   13'h0000, 0, 0, 0, 0, c);
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] bases [4] = '{13'h0100, 13'h1FFE, 13'h0000, 13'h0A00};
    logic [IW-1:0] ends  [4] = '{13'h0180, 13'h0002, 13'h0005, 13'h0A00};
    logic [LW-1:0] lens  [4] = '{16'h0080, 16'h0005, 16'h0004, 16'h2000};
    kind_t         kinds [4] = '{K_NOTIF, K_REQUEUE, K_NOTIF, K_ERR};
    int c;
    for (int i = 0; i < 4; i++) begin
      do_flow(0, FW'(8'h70 + i), bases[i], ends[i], lens[i], kinds[i],
              (kinds[i] == K_NOTIF) ? bases[i] : 13'h0000, 0, 0, 0, 0, c);
      compared++;
      if (c != 4) begin mismatched++; $display("FAIL b2b_latency flow %0d got cycle %0d want 4", i, c); end
    end
  endtask

  task automatic test_backpressure();
    int c;
    do_flow(0, 8'h51, 13'h0100, 13'h0180, 16'h0080, K_NOTIF, 13'h0100, 3, 5, 4, 0, c);
    compared++;
    if (c != 16) begin mismatched++; $display("FAIL backpressure_accept got cycle %0d want 16", c); end
  endtask

  task automatic test_reset_mid();
    int c;
    do_flow(0, 8'h61, 13'h0010, 13'h0020, 16'h0010, K_NOTIF, 13'h0010, 0, 0, 0, 1, c);
    do_flow(0, 8'h62, 13'h0040, 13'h0060, 16'h0010, K_NOTIF, 13'h0040, 0, 0, 0, 0, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rx_basic();
    test_rx_wrap();
    test_tx();
    test_err_and_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
